// File: rtl/tmds_word_align_pkg.sv
// Shared types and constants for TMDS word alignment: control tokens, FSM states, token decode.
package tmds_word_align_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } tmds_align_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] code;
  } tmds_ctrl_t;

  // code is forced to 0 on a miss so it can be registered without gating.
  function automatic tmds_ctrl_t tmds_ctrl_decode(input logic [9:0] win);
    tmds_ctrl_t r;
    r = '0;
    if (win == TMDS_CTRL_00)      r = '{hit: 1'b1, code: 2'd0};
    else if (win == TMDS_CTRL_01) r = '{hit: 1'b1, code: 2'd1};
    else if (win == TMDS_CTRL_10) r = '{hit: 1'b1, code: 2'd2};
    else if (win == TMDS_CTRL_11) r = '{hit: 1'b1, code: 2'd3};
    return r;
  endfunction

endpackage

// File: rtl/tmds_word_align_if.sv
// Deserializer-side input and aligned-symbol output bundle of one TMDS channel aligner.
interface tmds_word_align_if;
  logic [9:0] par_data_i;
  logic       par_valid_i;
  logic       resync_i;
  logic [9:0] data_o;
  logic       valid_o;
  logic       ctrl_o;
  logic [1:0] ctrl_code_o;
  logic [3:0] offset_o;
  logic       locked_o;

  modport slave (
    input  par_data_i, par_valid_i, resync_i,
    output data_o, valid_o, ctrl_o, ctrl_code_o, offset_o, locked_o
  );

  modport master (
    output par_data_i, par_valid_i, resync_i,
    input  data_o, valid_o, ctrl_o, ctrl_code_o, offset_o, locked_o
  );
endinterface

// File: rtl/tmds_word_align_ctrl_detect.sv
// Selects a 10-bit window out of {current, previous} word and flags TMDS control tokens.
module tmds_ctrl_detect
  import tmds_word_align_pkg::*;
(
  input  logic [9:0] cur_i,
  input  logic [9:0] prev_i,
  input  logic [3:0] offset_i,
  output logic [9:0] win_o,
  output logic       hit_o,
  output logic [1:0] code_o
);

  logic [19:0] cat;
  tmds_ctrl_t  dec;

  // prev holds the earlier bits, so offset 0 selects the previous word whole.
  assign cat    = {cur_i, prev_i};
  assign win_o  = 10'(cat >> offset_i);
  assign dec    = tmds_ctrl_decode(win_o);
  assign hit_o  = dec.hit;
  assign code_o = dec.code;

endmodule

// File: rtl/tmds_word_align.sv
// TMDS symbol boundary finder: hunts for control-token runs, then emits aligned symbols.
// state  | meaning
// SEARCH | no token run, slip offset after SEARCH_WIN non-token words
// VERIFY | counting consecutive tokens toward CTRL_RUN
// LOCKED | aligned; drop lock after LOSS_WIN words without a token
module tmds_word_align
  import tmds_word_align_pkg::*;
#(
  parameter int CTRL_RUN   = 8,
  parameter int SEARCH_WIN = 4096,
  parameter int LOSS_WIN   = 8192
) (
  input  logic              clk_i,
  input  logic              rst_i,
  tmds_word_align_if.slave  bus
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int WIN_W  = $clog2(SEARCH_WIN);
  localparam int LOSS_W = $clog2(LOSS_WIN);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WIN - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WIN - 1);

  tmds_align_state_t state_q, state_d;
  logic [3:0]        offset_q, offset_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic [9:0]        prev_q;
  logic [9:0]        data_q;
  logic              valid_q, ctrl_q, locked_q;
  logic [1:0]        code_q;

  logic [9:0] win;
  logic       hit;
  logic [1:0] code;

  tmds_ctrl_detect u_detect (
    .cur_i    (bus.par_data_i),
    .prev_i   (prev_q),
    .offset_i (offset_q),
    .win_o    (win),
    .hit_o    (hit),
    .code_o   (code)
  );

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    run_d     = run_q;
    win_cnt_d = win_cnt_q;
    loss_d    = loss_q;
    if (bus.resync_i) begin
      state_d   = SEARCH;
      offset_d  = 4'd0;
      run_d     = '0;
      win_cnt_d = '0;
      loss_d    = '0;
    end else if (bus.par_valid_i) begin
      case (state_q)
        SEARCH: begin
          if (hit) begin
            state_d = VERIFY;
            run_d   = RUN_W'(1);
          end else if (win_cnt_q == WIN_LAST) begin
            offset_d  = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            win_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end
        VERIFY: begin
          if (hit) begin
            run_d = run_q + 1'b1;
            if (run_q == RUN_LAST) begin
              state_d = LOCKED;
              loss_d  = '0;
            end
          end else begin
            state_d = SEARCH;
            run_d   = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            loss_d = '0;
          end else if (loss_q == LOSS_LAST) begin
            state_d   = SEARCH;
            win_cnt_d = '0;
            loss_d    = '0;
            run_d     = '0;
          end else begin
            loss_d = loss_q + 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= SEARCH;
      offset_q  <= 4'd0;
      run_q     <= '0;
      win_cnt_q <= '0;
      loss_q    <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      run_q     <= run_d;
      win_cnt_q <= win_cnt_d;
      loss_q    <= loss_d;
      locked_q  <= (state_d == LOCKED);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      valid_q <= bus.par_valid_i;
      if (bus.par_valid_i) begin
        prev_q <= bus.par_data_i;
        data_q <= win;
        ctrl_q <= hit;
        code_q <= code;
      end
    end
  end

  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.ctrl_o      = ctrl_q;
  assign bus.ctrl_code_o = code_q;
  assign bus.offset_o    = offset_q;
  assign bus.locked_o    = locked_q;

endmodule
